// File: rtl/hazard_pkg.sv
// Shared constants, select encodings and slot type for the pipeline hazard controller.
package hazard_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    // D-stage forward selects: GRF, M result, E pc8/imm result
    localparam logic [1:0] FWD_GRF   = 2'd0;
    localparam logic [1:0] FWD_M     = 2'd1;
    localparam logic [1:0] FWD_E     = 2'd2;
    // E-stage forward selects: W result, M result (nearer stage keeps the higher code)
    localparam logic [1:0] FWD_W     = 2'd1;
    localparam logic [1:0] FWD_E_M   = 2'd2;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10
    } md_op_e;

    typedef struct packed {
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] a3;
        logic [1:0] tnew;
    } slot_t;

    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x != 2'd0) ? x - 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div busy counter: loaded when an MD op leaves E, then counts down to idle.
module md_busy_cnt
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_md_op,
    output logic       o_busy
);

    logic [3:0] r_cnt;

    // Load on an MD op in E, otherwise count down while nonzero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_md_op == MD_MULT) begin
            r_cnt <= 4'(MULT_CYCLES);
        end else if (i_md_op == MD_DIV) begin
            r_cnt <= 4'(DIV_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller: shadow E/M/W write-back scoreboard, Tuse/Tnew compare, MD interlock.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_A1,
    input  logic [4:0] D_A2,
    input  logic [4:0] D_A3,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [1:0] D_Tnew,
    input  logic       D_md,
    input  logic [1:0] D_md_op,
    output logic       stall,
    output logic [1:0] FwdD_rs,
    output logic [1:0] FwdD_rt,
    output logic [1:0] FwdE_rs,
    output logic [1:0] FwdE_rt,
    output logic       FwdM_rt,
    output logic       md_busy
);

    // M keeps only rt/dest/Tnew and W only dest: nothing downstream reads the other fields
    slot_t      r_e;
    md_op_e     r_e_md;
    logic [4:0] r_m_a2;
    logic [4:0] r_m_a3;
    logic [1:0] r_m_tnew;
    logic [4:0] r_w_a3;

    logic       w_stall_rs;
    logic       w_stall_rt;
    logic       w_stall_md;
    logic       w_md_busy;

    function automatic logic reg_hazard(input logic [4:0] a, input logic [1:0] tuse,
                                        input slot_t e, input logic [4:0] m_a3,
                                        input logic [1:0] m_tnew);
        return (a != '0) && (((e.a3 == a) && (e.tnew > tuse)) ||
                             ((m_a3 == a) && (m_tnew > tuse)));
    endfunction

    function automatic logic [1:0] fwd_d(input logic [4:0] a, input slot_t e,
                                         input logic [4:0] m_a3, input logic [1:0] m_tnew);
        if (a == '0)                           return FWD_GRF;
        else if (e.a3 == a && e.tnew == 2'd0)  return FWD_E;
        else if (m_a3 == a && m_tnew == 2'd0)  return FWD_M;
        else                                   return FWD_GRF;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] a, input logic [4:0] m_a3,
                                         input logic [1:0] m_tnew, input logic [4:0] w_a3);
        if (a == '0)                           return FWD_GRF;
        else if (m_a3 == a && m_tnew == 2'd0)  return FWD_E_M;
        else if (w_a3 == a)                    return FWD_W;
        else                                   return FWD_GRF;
    endfunction

    // Shift the shadow scoreboard with the pipeline; a stall inserts a bubble into E
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e      <= '0;
            r_e_md   <= MD_NONE;
            r_m_a2   <= '0;
            r_m_a3   <= '0;
            r_m_tnew <= '0;
            r_w_a3   <= '0;
        end else begin
            r_w_a3   <= r_m_a3;
            r_m_a2   <= r_e.a2;
            r_m_a3   <= r_e.a3;
            r_m_tnew <= sat_dec(r_e.tnew);
            if (stall) begin
                r_e    <= '0;
                r_e_md <= MD_NONE;
            end else begin
                r_e    <= '{a1: D_A1, a2: D_A2, a3: D_A3, tnew: D_Tnew};
                r_e_md <= md_op_e'(D_md_op);
            end
        end
    end

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_cnt (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_md_op (r_e_md),
        .o_busy  (w_md_busy)
    );

    assign w_stall_rs = reg_hazard(D_A1, D_Tuse_rs, r_e, r_m_a3, r_m_tnew);
    assign w_stall_rt = reg_hazard(D_A2, D_Tuse_rt, r_e, r_m_a3, r_m_tnew);
    assign w_stall_md = D_md && ((r_e_md != MD_NONE) || w_md_busy);

    // Stall and forwarding selects from the scoreboard and the D-stage operands
    always_comb begin
        stall   = w_stall_rs | w_stall_rt | w_stall_md;
        FwdD_rs = fwd_d(D_A1, r_e, r_m_a3, r_m_tnew);
        FwdD_rt = fwd_d(D_A2, r_e, r_m_a3, r_m_tnew);
        FwdE_rs = fwd_e(r_e.a1, r_m_a3, r_m_tnew, r_w_a3);
        FwdE_rt = fwd_e(r_e.a2, r_m_a3, r_m_tnew, r_w_a3);
        FwdM_rt = (r_m_a2 != '0) && (r_w_a3 == r_m_a2);
        md_busy = w_md_busy;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: pipeline reference model feeding a scoreboard queue.
module tb_hazard_ctrl;

    typedef struct {
        logic [4:0] a1, a2, a3;
        logic [1:0] tuse_rs, tuse_rt, tnew;
        logic       md;
        logic [1:0] md_op;
    } instr_t;

    typedef struct {
        logic       stall;
        logic [1:0] fdrs, fdrt, fers, fert;
        logic       fmrt, busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_A1, D_A2, D_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew, D_md_op;
    logic       D_md;
    logic       stall, FwdM_rt, md_busy;
    logic [1:0] FwdD_rs, FwdD_rt, FwdE_rs, FwdE_rt;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .D_A1(D_A1), .D_A2(D_A2), .D_A3(D_A3),
        .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_Tnew(D_Tnew),
        .D_md(D_md), .D_md_op(D_md_op),
        .stall(stall), .FwdD_rs(FwdD_rs), .FwdD_rt(FwdD_rt),
        .FwdE_rs(FwdE_rs), .FwdE_rt(FwdE_rt), .FwdM_rt(FwdM_rt), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference model: index 0 = E, 1 = M, 2 = W
    logic [4:0] m_a1[3], m_a2[3], m_a3[3];
    logic [1:0] m_tnew[3];
    logic [1:0] m_emd;
    int         m_cnt;

    instr_t stream[$];
    exp_t   sbq[$];
    instr_t cur;
    instr_t nop;

    int seg_stalls, seg_busy, seg_fmrt, seg_fers_w, seg_fdrs_m, seg_fdrs_e;

    function automatic instr_t mk(int a1, int a2, int a3, int trs, int trt, int tnew,
                                  int md, int op);
        instr_t x;
        x.a1 = 5'(a1); x.a2 = 5'(a2); x.a3 = 5'(a3);
        x.tuse_rs = 2'(trs); x.tuse_rt = 2'(trt); x.tnew = 2'(tnew);
        x.md = 1'(md); x.md_op = 2'(op);
        return x;
    endfunction

    function automatic logic [1:0] dsel(logic [4:0] a);
        for (int s = 0; s < 2; s++)
            if (a != 0 && m_a3[s] == a && m_tnew[s] == 0) return 2'(2 - s);
        return 2'd0;
    endfunction

    function automatic logic [1:0] esel(logic [4:0] a);
        for (int s = 1; s < 3; s++)
            if (a != 0 && m_a3[s] == a && (s == 2 || m_tnew[s] == 0)) return 2'(3 - s);
        return 2'd0;
    endfunction

    function automatic exp_t model_out(instr_t d);
        exp_t x;
        x.stall = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (d.a1 != 0 && m_a3[s] == d.a1 && m_tnew[s] > d.tuse_rs) x.stall = 1'b1;
            if (d.a2 != 0 && m_a3[s] == d.a2 && m_tnew[s] > d.tuse_rt) x.stall = 1'b1;
        end
        if (d.md && (m_emd != 0 || m_cnt != 0)) x.stall = 1'b1;
        x.fdrs = dsel(d.a1);
        x.fdrt = dsel(d.a2);
        x.fers = esel(m_a1[0]);
        x.fert = esel(m_a2[0]);
        x.fmrt = (m_a2[1] != 0) && (m_a3[2] == m_a2[1]);
        x.busy = (m_cnt != 0);
        return x;
    endfunction

    task automatic model_clock(instr_t d, logic stl);
        for (int s = 2; s > 0; s--) begin
            m_a1[s]   = m_a1[s-1];
            m_a2[s]   = m_a2[s-1];
            m_a3[s]   = m_a3[s-1];
            m_tnew[s] = (m_tnew[s-1] == 0) ? 2'd0 : m_tnew[s-1] - 2'd1;
        end
        if (m_emd == 2'b01)      m_cnt = 5;
        else if (m_emd == 2'b10) m_cnt = 10;
        else if (m_cnt > 0)      m_cnt--;
        if (stl) begin
            m_a1[0] = 0; m_a2[0] = 0; m_a3[0] = 0; m_tnew[0] = 0; m_emd = 0;
        end else begin
            m_a1[0] = d.a1; m_a2[0] = d.a2; m_a3[0] = d.a3; m_tnew[0] = d.tnew; m_emd = d.md_op;
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            m_a1[s] = 0; m_a2[s] = 0; m_a3[s] = 0; m_tnew[s] = 0;
        end
        m_emd = 0;
        m_cnt = 0;
    endtask

    task automatic drive(instr_t d);
        D_A1 = d.a1; D_A2 = d.a2; D_A3 = d.a3;
        D_Tuse_rs = d.tuse_rs; D_Tuse_rt = d.tuse_rt; D_Tnew = d.tnew;
        D_md = d.md; D_md_op = d.md_op;
    endtask

    task automatic clear_seg();
        seg_stalls = 0; seg_busy = 0; seg_fmrt = 0;
        seg_fers_w = 0; seg_fdrs_m = 0; seg_fdrs_e = 0;
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        drive(cur);
        sbq.push_back(model_out(cur));
        #1;
        e = sbq.pop_front();
        check("stall",   stall,   e.stall);
        check("FwdD_rs", FwdD_rs, e.fdrs);
        check("FwdD_rt", FwdD_rt, e.fdrt);
        check("FwdE_rs", FwdE_rs, e.fers);
        check("FwdE_rt", FwdE_rt, e.fert);
        check("FwdM_rt", FwdM_rt, e.fmrt);
        check("md_busy", md_busy, e.busy);
        if (stall)        seg_stalls++;
        if (md_busy)      seg_busy++;
        if (FwdM_rt)      seg_fmrt++;
        if (FwdE_rs == 1) seg_fers_w++;
        if (FwdD_rs == 1) seg_fdrs_m++;
        if (FwdD_rs == 2) seg_fdrs_e++;
        @(posedge clk);
        model_clock(cur, e.stall);
        if (!e.stall) cur = (stream.size() > 0) ? stream.pop_front() : nop;
    endtask

    task automatic run_seg(int drain);
        int guard = 0;
        clear_seg();
        for (int i = 0; i < drain; i++) stream.push_back(nop);
        cur = stream.pop_front();
        while (stream.size() > 0) begin
            if (guard >= 400) begin
                check("seg_budget", stream.size(), 0);
                stream.delete();
                break;
            end
            step();
            guard++;
        end
    endtask

    task automatic check_zero(string pfx);
        check({pfx, "_stall"},   stall,   0);
        check({pfx, "_FwdD_rs"}, FwdD_rs, 0);
        check({pfx, "_FwdD_rt"}, FwdD_rt, 0);
        check({pfx, "_FwdE_rs"}, FwdE_rs, 0);
        check({pfx, "_FwdE_rt"}, FwdE_rt, 0);
        check({pfx, "_FwdM_rt"}, FwdM_rt, 0);
        check({pfx, "_md_busy"}, md_busy, 0);
    endtask

    initial begin
        instr_t lw1, addu1, mflo;
        nop   = mk(0, 0, 0, 3, 3, 0, 0, 0);
        lw1   = mk(5, 1, 1, 1, 3, 2, 0, 0);
        addu1 = mk(1, 3, 2, 1, 1, 1, 0, 0);
        mflo  = mk(0, 0, 7, 3, 3, 1, 1, 0);
        cur   = nop;
        model_reset();
        reset = 1'b1;
        drive(nop);
        #2;
        check_zero("rst0");
        @(posedge clk);
        #1 reset = 1'b0;

        // load-use: one stall, then W forward into E operand A
        stream = '{lw1, addu1};
        run_seg(3);
        check("lu_stalls", seg_stalls, 1);
        check("lu_fwdE_W", seg_fers_w, 1);

        // ALU result to branch in D
        stream = '{mk(4, 5, 1, 1, 1, 1, 0, 0), mk(1, 6, 0, 0, 0, 0, 0, 0)};
        run_seg(3);
        check("br_stalls", seg_stalls, 1);
        check("br_fwdD_M", seg_fdrs_m, 1);

        // jal then jr $31: E-stage pc8 forward, no stall
        stream = '{mk(0, 0, 31, 3, 3, 0, 0, 0), mk(31, 0, 0, 0, 3, 0, 0, 0)};
        run_seg(3);
        check("jr_stalls", seg_stalls, 0);
        check("jr_fwdD_E", seg_fdrs_e, 1);

        // $0 is never a hazard source
        stream = '{mk(5, 0, 0, 1, 3, 2, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0)};
        run_seg(3);
        check("z_stalls", seg_stalls, 0);
        check("z_fwdD", seg_fdrs_e + seg_fdrs_m, 0);

        // load then store of the loaded reg: W forward into M store data
        stream = '{lw1, mk(5, 1, 0, 1, 2, 0, 0, 0)};
        run_seg(4);
        check("sw_stalls", seg_stalls, 0);
        check("sw_fwdM", seg_fmrt, 1);

        // mult then mflo
        stream = '{mk(4, 5, 0, 1, 1, 1, 1, 1), mflo};
        run_seg(3);
        check("mult_stalls", seg_stalls, 6);
        check("mult_busy", seg_busy, 5);

        // div then mflo
        stream = '{mk(4, 5, 0, 1, 1, 1, 1, 2), mflo};
        run_seg(3);
        check("div_stalls", seg_stalls, 11);
        check("div_busy", seg_busy, 10);

        // random mix over a small register set
        for (int i = 0; i < 60; i++) begin
            instr_t r;
            int md;
            md = ($urandom_range(0, 7) == 0) ? 1 : 0;
            r = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                   md, md ? $urandom_range(0, 2) : 0);
            stream.push_back(r);
        end
        run_seg(12);

        // reset in the middle of a div countdown and a load-use stall
        clear_seg();
        stream = '{mk(4, 5, 0, 1, 1, 1, 1, 2), nop, nop, nop, lw1, addu1};
        cur = stream.pop_front();
        repeat (5) step();
        @(negedge clk);
        drive(cur);
        #1;
        check("pre_rst_stall", stall, 1);
        check("pre_rst_busy", md_busy, 1);
        #1 reset = 1'b1;
        #1;
        check_zero("rst_mid");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        reset = 1'b0;
        stream.delete();
        cur = mflo;
        clear_seg();
        step();
        check("mflo_after_rst", seg_stalls, 0);
        run_seg(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/forward controller for the 5-stage pipeline; the producer of the `stall` that freezes PC and the D register and flushes the E register.
- Keeps its own shadow scoreboard of in-flight E/M/W write-backs (dest register, Tnew, source regs), updated in lockstep with the pipeline registers.
- Compares the D-stage instruction's Tuse against that scoreboard to decide stall and forwarding-mux selects.
- Owns the mult/div busy counter, so HI/LO-class instructions stall while the MD unit is busy.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu leaves E
- DIV_CYCLES, 10, busy cycles after a div/divu leaves E

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- D_A1  in  5  rs of D instr
- D_A2  in  5  rt of D instr
- D_A3  in  5  dest of D instr; 0 = no write
- D_Tuse_rs  in  2  cycles until rs is needed; 3 = not used
- D_Tuse_rt  in  2  cycles until rt is needed; 3 = not used
- D_Tnew  in  2  cycles after entering E until the result exists (0 = lui/jal, 1 = ALU, 2 = load)
- D_md  in  1  D instr uses MD unit (mult/div/mfhi/mflo/mthi/mtlo)
- D_md_op  in  2  00 none, 01 mult/multu, 10 div/divu
- stall  out  1  freeze PC and D register; flush E register
- FwdD_rs  out  2  D-stage rs: 0 GRF, 1 M result, 2 E pc8/imm result
- FwdD_rt  out  2  same encoding, for rt
- FwdE_rs  out  2  E ALU operand A: 0 E_V1, 1 W result, 2 M result
- FwdE_rt  out  2  same encoding, for operand B
- FwdM_rt  out  1  M store data: 0 M_V2, 1 W result
- md_busy  out  1  MD unit busy, for observation

Behaviour:
- State: slots E, M, W. Each holds A1, A2, A3 (5b), Tnew (2b). Slot E also holds md_op. Plus md_cnt (4b).
- Reset (async): all slot fields 0, md_cnt 0. Every output is therefore 0 during and right after reset.
- Per rising edge, not stall:
  - E <= {D_A1, D_A2, D_A3, D_Tnew, D_md_op}
  - M <= E, with Tnew = sat_dec(E.Tnew)
  - W <= M, with Tnew = sat_dec(M.Tnew)
- Per rising edge, stall: E <= bubble (all fields 0); M and W still advance as above.
- sat_dec(x) = x - 1 if x != 0, else 0.
- A3 == 0 never matches and never forwards; $0 is not a hazard source.
- Stall (combinational), for src in {rs, rt} with A != 0:
  - (E.A3 == A && E.Tnew > Tuse) or
  - (M.A3 == A && M.Tnew > Tuse)
  - W never stalls; the GRF handles write-then-read internally.
- MD stall: D_md && (E.md_op != 0 || md_cnt != 0). OR with the register stall.
- md_cnt:
  - When E.md_op == 01, load MULT_CYCLES on the next edge; when 10, load DIV_CYCLES.
  - Otherwise, if nonzero, decrement by 1 per edge.
  - md_busy = (md_cnt != 0).
  - A load while md_cnt != 0 cannot happen (the MD stall prevents it).
- FwdD_x, with A != 0:
  - 2 if E.A3 == A && E.Tnew == 0
  - else 1 if M.A3 == A && M.Tnew == 0
  - else 0
- FwdE_x, using E.A1 / E.A2:
  - 2 if M.A3 match && M.Tnew == 0
  - else 1 if W.A3 match
  - else 0
  - The nearer stage always wins.
- FwdM_rt = 1 iff W.A3 == M.A2 != 0.
- Selects are valid even during stall; the bubble makes stale selects harmless.
- Reset mid-stall: state clears immediately; stall deasserts asynchronously unless the D inputs alone create an MD conflict (impossible with md_cnt = 0 and E empty).

Decomposition:
- Shared package `hazard_pkg` holds:
  - Tnew/Tuse constants: TUSE_NONE = 3
  - forward-select encodings: FWD_GRF, FWD_M, FWD_E, FWD_W
  - MD op codes: MD_NONE, MD_MULT, MD_DIV
- One natural sub-module: `md_busy_cnt` (counter, load/decrement, busy flag).
- Slot registers and compare logic stay in hazard_ctrl.

Test Plan:
- Load-use: lw $1 in D (A3=1, Tnew=2) then addu $2,$1,$3 (Tuse_rs=1) → 1 stall cycle; E bubble has A3=0; the next cycle FwdE_rs=1 (W).
- ALU-to-branch: addu $1 in E (Tnew=1), beq with rs=$1 in D (Tuse=0) → stall=1 for 1 cycle, then FwdD_rs=1 (M).
- jal in E (A3=31, Tnew=0) and jr $31 in D → stall=0, FwdD_rs=2.
- $0 hazard: E.A3=0 with Tnew=2, D rs=0 Tuse=0 → stall=0, FwdD_rs=0.
- MD: mult passes E → md_busy high for exactly 5 cycles; mflo in D stalls 6 cycles total (E cycle + 5), then proceeds. With div the count is 10.
- Reset asserted mid-MD (md_cnt=7) and mid load-use → outputs 0 asynchronously; after release, mflo in D gives stall=0.
